// File: rtl/main_bus_arbiter_pkg.sv
// Shared definitions for the main bus arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   BUS_BEATS    : default data cycles per burst after the address cycle
//   ARB_TIMEOUT  : default cycles a granted master may wait before AddrValid
package main_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_XFER,
        ARB_TURN
    } arb_state_t;

    localparam int unsigned BUS_BEATS   = 4;
    localparam int unsigned ARB_TIMEOUT = 8;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker (combinational).
// Finds the first set request bit searching upward from ptr_i, wrapping modulo
// NumMasters, by scanning a doubled copy of the request vector.
//   req_i   : per-master request vector
//   ptr_i   : index holding highest priority
//   valid_o : at least one request is set
//   index_o : index of the chosen master (0 when valid_o is low)
module rr_priority_pick #(
    parameter int unsigned NumMasters = 4,
    parameter int unsigned IdxW       = $clog2(NumMasters)  // derived, leave at default
) (
    input  logic [NumMasters-1:0] req_i,
    input  logic [IdxW-1:0]       ptr_i,
    output logic                  valid_o,
    output logic [IdxW-1:0]       index_o
);

    logic [2*NumMasters-1:0] req_dbl;
    int unsigned             pos;

    // Doubling the vector turns the wrap-around search into a linear one.
    assign req_dbl = {req_i, req_i};

    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        pos     = 0;
        for (int unsigned k = 0; k < NumMasters; k++) begin
            pos = 32'(ptr_i) + k;
            if (!valid_o && req_dbl[pos]) begin
                valid_o = 1'b1;
                index_o = (pos >= NumMasters) ? IdxW'(pos - NumMasters) : IdxW'(pos);
            end
        end
    end

endmodule

// File: rtl/main_bus_arbiter.sv
// Main bus arbiter: grants one master at a time for a full burst (address cycle
// plus BEATS data cycles), inserts one turnaround cycle, then re-arbitrates
// round-robin. Only observes the bus.
//   clk          : bus clock
//   resetH       : asynchronous active-high reset
//   req          : per-master level request
//   AddrValid    : observed main-bus address strobe
//   gnt          : registered one-hot grant
//   owner        : index of the current or last granted master
//   bus_busy     : high whenever the FSM is not idle
//   timeout_err  : one-cycle pulse when a grant is revoked by timeout
//   protocol_err : one-cycle pulse when AddrValid is seen outside GRANT
module main_bus_arbiter
    import main_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned BEATS       = BUS_BEATS,
    parameter int unsigned TIMEOUT     = ARB_TIMEOUT,
    parameter int unsigned IdxW        = $clog2(NUM_MASTERS)  // derived, leave at default
) (
    input  logic                   clk,
    input  logic                   resetH,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   AddrValid,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IdxW-1:0]        owner,
    output logic                   bus_busy,
    output logic                   timeout_err,
    output logic                   protocol_err
);

    localparam int unsigned CntMax = (BEATS > TIMEOUT) ? BEATS : TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [CntW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                   busy_q;
    logic                   timeout_err_q, timeout_err_d;
    logic                   protocol_err_q, protocol_err_d;

    logic                   pick_valid;
    logic [IdxW-1:0]        pick_idx;

    rr_priority_pick #(
        .NumMasters (NUM_MASTERS)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        beat_cnt_d     = beat_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        timeout_err_d  = 1'b0;
        protocol_err_d = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                protocol_err_d = AddrValid;
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    // The master just granted drops to lowest priority.
                    ptr_d     = (pick_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : pick_idx + IdxW'(1);
                    tmo_cnt_d = '0;
                    state_d   = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (AddrValid) begin
                    beat_cnt_d = '0;
                    state_d    = ARB_XFER;
                end else if (tmo_cnt_q == CntW'(TIMEOUT - 1)) begin
                    gnt_d         = '0;
                    timeout_err_d = 1'b1;
                    state_d       = ARB_TURN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CntW'(1);
                end
            end
            ARB_XFER: begin
                protocol_err_d = AddrValid;
                if (beat_cnt_q == CntW'(BEATS - 1)) begin
                    gnt_d   = '0;
                    state_d = ARB_TURN;
                end else begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                end
            end
            ARB_TURN: begin
                protocol_err_d = AddrValid;
                state_d        = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state_q        <= ARB_IDLE;
            gnt_q          <= '0;
            owner_q        <= '0;
            ptr_q          <= '0;
            beat_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            owner_q        <= owner_d;
            ptr_q          <= ptr_d;
            beat_cnt_q     <= beat_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            busy_q         <= (state_d != ARB_IDLE);
            timeout_err_q  <= timeout_err_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign gnt          = gnt_q;
    assign owner        = owner_q;
    assign bus_busy     = busy_q;
    assign timeout_err  = timeout_err_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Self-checking bench for main_bus_arbiter (4 masters, 4 beats, timeout 8).
module tb_main_bus_arbiter;

    logic       clk;
    logic       resetH;
    logic [3:0] req;
    logic       AddrValid;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout_err;
    logic       protocol_err;

    int checks = 0;
    int errors = 0;

    main_bus_arbiter #(
        .NUM_MASTERS (4),
        .BEATS       (4),
        .TIMEOUT     (8)
    ) dut (
        .clk          (clk),
        .resetH       (resetH),
        .req          (req),
        .AddrValid    (AddrValid),
        .gnt          (gnt),
        .owner        (owner),
        .bus_busy     (bus_busy),
        .timeout_err  (timeout_err),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       av;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       terr;
        logic       perr;
    } vec_t;

    vec_t vec [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, then look at outputs just after the rising edge.
    task automatic step(input logic [3:0] r, input logic a);
        @(negedge clk);
        req       = r;
        AddrValid = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [3:0] g, input logic [1:0] o,
                           input logic b, input logic te, input logic pe);
        chk({name, ".gnt"},   32'(gnt),          32'(g));
        chk({name, ".owner"}, 32'(owner),        32'(o));
        chk({name, ".busy"},  32'(bus_busy),     32'(b));
        chk({name, ".terr"},  32'(timeout_err),  32'(te));
        chk({name, ".perr"},  32'(protocol_err), 32'(pe));
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetH = 1'b1;
        req = '0;
        AddrValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetH = 1'b0;
    endtask

    initial begin
        int tpulses;

        // req av  | gnt owner busy terr perr (outputs after the edge)
        vec[0]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
        vec[1]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
        vec[2]  = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
        vec[3]  = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
        vec[4]  = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
        vec[5]  = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
        vec[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
        vec[7]  = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1};
        vec[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};
        vec[10] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
        vec[11] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
        vec[12] = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
        vec[13] = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
        vec[14] = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
        vec[15] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0};
        vec[16] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
        vec[17] = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[18] = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[19] = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1};
        vec[20] = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[21] = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[22] = '{4'b0101, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0};
        vec[23] = '{4'b0101, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
        vec[24] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};

        resetH    = 1'b1;
        req       = '0;
        AddrValid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetH = 1'b0;

        // Single burst, protocol errors, fairness after pointer moves.
        for (int i = 0; i < 25; i++) begin
            step(vec[i].req, vec[i].av);
            chk_all($sformatf("vec%0d", i), vec[i].gnt, vec[i].owner, vec[i].busy,
                    vec[i].terr, vec[i].perr);
        end

        // Asynchronous reset in the middle of a data phase.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        chk("midxfer.pre_gnt", 32'(gnt), 32'(4'b0100));
        #2;
        resetH = 1'b1;
        #1;
        chk_all("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        resetH = 1'b0;
        step(4'b0100, 1'b0);
        chk("post_reset.gnt", 32'(gnt), 32'(4'b0100));
        chk("post_reset.owner", 32'(owner), 32'd2);

        // Round-robin with every master requesting.
        do_reset();
        step(4'b1111, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(1 << (k % 4)));
            chk($sformatf("rr%0d.owner", k), 32'(owner), 32'(k % 4));
            step(4'b1111, 1'b1);
            for (int b = 0; b < 3; b++) step(4'b1111, 1'b0);
            chk($sformatf("rr%0d.last_beat", k), 32'(gnt), 32'(1 << (k % 4)));
            step(4'b1111, 1'b0);
            chk($sformatf("rr%0d.turn_gnt", k), 32'(gnt), 32'd0);
            chk($sformatf("rr%0d.turn_busy", k), 32'(bus_busy), 32'd1);
            step(4'b1111, 1'b0);
            chk($sformatf("rr%0d.idle_busy", k), 32'(bus_busy), 32'd0);
            if (k < 4) step(4'b1111, 1'b0);
        end

        // Timeout: master 3 never drives AddrValid.
        do_reset();
        step(4'b1000, 1'b0);
        chk("tmo.gnt", 32'(gnt), 32'(4'b1000));
        tpulses = 0;
        for (int c = 1; c <= 7; c++) begin
            step(4'b1001, 1'b0);
            chk($sformatf("tmo.hold%0d", c), 32'(gnt), 32'(4'b1000));
            if (timeout_err) tpulses++;
        end
        step(4'b0001, 1'b0);
        chk("tmo.revoked", 32'(gnt), 32'd0);
        chk("tmo.busy", 32'(bus_busy), 32'd1);
        if (timeout_err) tpulses++;
        step(4'b0001, 1'b0);
        if (timeout_err) tpulses++;
        chk("tmo.idle_gnt", 32'(gnt), 32'd0);
        step(4'b0001, 1'b0);
        if (timeout_err) tpulses++;
        chk("tmo.next_gnt", 32'(gnt), 32'(4'b0001));
        chk("tmo.pulses", 32'(tpulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
